// File: rtl/smbm_param.sv
// Sorted multi-metric bitmap manager: one value-sorted list per metric, masked arg-min
// queries, and ADD/DELETE/UPDATE/CLEAR behind a single-outstanding valid/ready request port.
module smbm_param #(
   parameter int ID_W        = 7,
   parameter int NUM_METRICS = 2,
   parameter int METRIC_W    = 8,
   parameter int SEL_W       = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [2:0]                      req_op,
   input  logic [ID_W-1:0]                 req_id,
   input  logic [NUM_METRICS*METRIC_W-1:0] req_metrics,
   input  logic [(1<<ID_W)-1:0]            req_mask,
   input  logic [SEL_W-1:0]                metric_sel,
   output logic                            rsp_valid,
   output logic [2:0]                      rsp_status,
   output logic [ID_W-1:0]                 rsp_id,
   output logic [METRIC_W-1:0]             rsp_val,
   output logic [ID_W:0]                   count,
   output logic                            full,
   output logic                            empty
);
   localparam int N  = 1 << ID_W;
   localparam int CW = ID_W + 1;
   localparam logic [SEL_W:0] NUM_SEL = (SEL_W+1)'(NUM_METRICS);

   localparam logic [2:0] OP_ADD = 3'b000, OP_DELETE = 3'b001, OP_READ = 3'b010,
                          OP_UPDATE = 3'b011, OP_CLEAR = 3'b100;
   localparam logic [2:0] ST_OK = 3'b000, ST_FULL = 3'b001, ST_NOT_FOUND = 3'b010,
                          ST_DUPLICATE = 3'b011, ST_BAD_OP = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_COMMIT, S_RESP} state_t;
   state_t r_state, w_next;

   // latched request
   logic [2:0]                      r_op;
   logic [ID_W-1:0]                 r_id;
   logic [NUM_METRICS*METRIC_W-1:0] r_metrics;
   logic [N-1:0]                    r_mask;
   logic [SEL_W-1:0]                r_sel;
   logic                            r_phase;

   logic [CW-1:0]       r_count;
   logic [N-1:0]        r_present;
   logic [METRIC_W-1:0] r_val [NUM_METRICS][N];
   logic [ID_W-1:0]     r_lid [NUM_METRICS][N];

   logic [CW-1:0]       r_ins   [NUM_METRICS];
   logic [CW-1:0]       r_match [NUM_METRICS];
   logic                r_rd_hit;
   logic [ID_W-1:0]     r_rd_id;
   logic [METRIC_W-1:0] r_rd_val;

   logic                r_rsp_valid;
   logic [2:0]          r_rsp_status;
   logic [ID_W-1:0]     r_rsp_id;
   logic [METRIC_W-1:0] r_rsp_val;

   logic [CW-1:0]       w_ins   [NUM_METRICS];
   logic [CW-1:0]       w_match [NUM_METRICS];
   logic                w_rd_hit;
   logic [ID_W-1:0]     w_rd_id;
   logic [METRIC_W-1:0] w_rd_val;

   logic                w_commit, w_present, w_full;
   logic                w_do_ins, w_do_del, w_do_clr, w_to_phase1;
   logic [2:0]          w_status;
   logic [ID_W-1:0]     w_rsp_id;
   logic [METRIC_W-1:0] w_rsp_val;

   assign req_ready  = (r_state == S_IDLE) && !rst;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_status = r_rsp_status;
   assign rsp_id     = r_rsp_id;
   assign rsp_val    = r_rsp_val;
   assign w_full     = (r_count == CW'(N));
   assign count      = r_count;
   assign full       = w_full;
   assign empty      = (r_count == '0);
   assign w_commit   = (r_state == S_COMMIT);
   assign w_present  = r_present[r_id];

   // Descending scans so the lowest qualifying slot wins; insert lands after equal values.
   always_comb begin
      for (int k = 0; k < NUM_METRICS; k++) begin
         w_ins[k]   = r_count;
         w_match[k] = '0;
         for (int i = N-1; i >= 0; i--) begin
            if (CW'(i) < r_count) begin
               if (r_val[k][i] > r_metrics[k*METRIC_W +: METRIC_W]) w_ins[k] = CW'(i);
               if (r_lid[k][i] == r_id) w_match[k] = CW'(i);
            end
         end
      end
      w_rd_hit = 1'b0;
      w_rd_id  = '0;
      w_rd_val = '1;
      for (int k = 0; k < NUM_METRICS; k++) begin
         if ({1'b0, r_sel} == (SEL_W+1)'(k)) begin
            for (int i = N-1; i >= 0; i--) begin
               if ((CW'(i) < r_count) && r_mask[r_lid[k][i]]) begin
                  w_rd_hit = 1'b1;
                  w_rd_id  = r_lid[k][i];
                  w_rd_val = r_val[k][i];
               end
            end
         end
      end
   end

   // COMMIT decision; DUPLICATE takes precedence over FULL.
   always_comb begin
      w_status    = ST_OK;
      w_do_ins    = 1'b0;
      w_do_del    = 1'b0;
      w_do_clr    = 1'b0;
      w_to_phase1 = 1'b0;
      w_rsp_id    = '0;
      w_rsp_val   = '0;
      case (r_op)
         OP_ADD: begin
            if (w_present)   w_status = ST_DUPLICATE;
            else if (w_full) w_status = ST_FULL;
            else             w_do_ins = 1'b1;
         end
         OP_DELETE: begin
            if (!w_present) w_status = ST_NOT_FOUND;
            else            w_do_del = 1'b1;
         end
         OP_UPDATE: begin
            if (r_phase) w_do_ins = 1'b1;
            else if (!w_present) w_status = ST_NOT_FOUND;
            else begin
               w_do_del    = 1'b1;
               w_to_phase1 = 1'b1;
            end
         end
         OP_READ: begin
            if ({1'b0, r_sel} >= NUM_SEL) w_status = ST_BAD_OP;
            else if (r_rd_hit) begin
               w_rsp_id  = r_rd_id;
               w_rsp_val = r_rd_val;
            end else begin
               w_status  = ST_NOT_FOUND;
               w_rsp_val = '1;
            end
         end
         OP_CLEAR: w_do_clr = 1'b1;
         default:  w_status = ST_BAD_OP;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (req_valid && req_ready) w_next = S_LOOKUP;
         S_LOOKUP: w_next = S_COMMIT;
         S_COMMIT: w_next = w_to_phase1 ? S_LOOKUP : S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count      <= '0;
         r_present    <= '0;
         r_phase      <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_status <= '0;
         r_rsp_id     <= '0;
         r_rsp_val    <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (req_valid && req_ready) r_phase <= 1'b0;
         if (w_commit) begin
            if (w_to_phase1) r_phase <= 1'b1;
            if (w_do_ins) begin
               r_count          <= r_count + CW'(1);
               r_present[r_id] <= 1'b1;
            end
            if (w_do_del) begin
               r_count          <= r_count - CW'(1);
               r_present[r_id] <= 1'b0;
            end
            if (w_do_clr) begin
               r_count   <= '0;
               r_present <= '0;
            end
            if (!w_to_phase1) begin
               r_rsp_valid  <= 1'b1;
               r_rsp_status <= w_status;
               r_rsp_id     <= w_rsp_id;
               r_rsp_val    <= w_rsp_val;
            end
         end
      end
   end

   // Request latch, lookup results and list storage; slot contents past count are don't-care.
   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         r_op      <= req_op;
         r_id      <= req_id;
         r_metrics <= req_metrics;
         r_mask    <= req_mask;
         r_sel     <= metric_sel;
      end
      if (r_state == S_LOOKUP) begin
         for (int k = 0; k < NUM_METRICS; k++) begin
            r_ins[k]   <= w_ins[k];
            r_match[k] <= w_match[k];
         end
         r_rd_hit <= w_rd_hit;
         r_rd_id  <= w_rd_id;
         r_rd_val <= w_rd_val;
      end
      if (w_commit && w_do_ins) begin
         for (int k = 0; k < NUM_METRICS; k++) begin
            for (int i = 0; i < N; i++) begin
               if (CW'(i) == r_ins[k]) begin
                  r_val[k][i] <= r_metrics[k*METRIC_W +: METRIC_W];
                  r_lid[k][i] <= r_id;
               end
            end
            for (int i = 1; i < N; i++) begin
               if (CW'(i) > r_ins[k]) begin
                  r_val[k][i] <= r_val[k][i-1];
                  r_lid[k][i] <= r_lid[k][i-1];
               end
            end
         end
      end
      if (w_commit && w_do_del) begin
         for (int k = 0; k < NUM_METRICS; k++) begin
            for (int i = 0; i < N-1; i++) begin
               if (CW'(i) >= r_match[k]) begin
                  r_val[k][i] <= r_val[k][i+1];
                  r_lid[k][i] <= r_lid[k][i+1];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_smbm_param.sv
// Directed bench for smbm_param: hand-computed responses, latencies and occupancy checked
// with immediate assertions in one linear stimulus sequence.
module tb_smbm_param;
   localparam int ID_W = 7;
   localparam int NM   = 2;
   localparam int MW   = 8;
   localparam int SW   = 1;
   localparam int N    = 128;

   localparam logic [2:0] OP_ADD = 3'b000, OP_DELETE = 3'b001, OP_READ = 3'b010,
                          OP_UPDATE = 3'b011, OP_CLEAR = 3'b100, OP_ILLEGAL = 3'b111;
   localparam logic [2:0] ST_OK = 3'b000, ST_NOT_FOUND = 3'b010,
                          ST_DUPLICATE = 3'b011, ST_BAD_OP = 3'b100;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_op;
   logic [ID_W-1:0] req_id;
   logic [NM*MW-1:0] req_metrics;
   logic [N-1:0]    req_mask;
   logic [SW-1:0]   metric_sel;
   logic            rsp_valid;
   logic [2:0]      rsp_status;
   logic [ID_W-1:0] rsp_id;
   logic [MW-1:0]   rsp_val;
   logic [ID_W:0]   count;
   logic            full;
   logic            empty;

   smbm_param #(.ID_W(ID_W), .NUM_METRICS(NM), .METRIC_W(MW), .SEL_W(SW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_id(req_id), .req_metrics(req_metrics), .req_mask(req_mask),
      .metric_sel(metric_sel), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
      .rsp_id(rsp_id), .rsp_val(rsp_val), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int lat;
   logic [2:0]      got_status;
   logic [ID_W-1:0] got_id;
   logic [MW-1:0]   got_val;
   logic [N-1:0]    all_ones;
   logic [N-1:0]    no_bits;
   logic [N-1:0]    mask_5_9;
   logic            saw_rsp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request, wait for its response pulse, and check that the pulse lasts one cycle.
   task automatic do_req(input logic [2:0] op, input logic [ID_W-1:0] id, input logic [MW-1:0] m0,
                         input logic [MW-1:0] m1, input logic [N-1:0] mask, input logic [SW-1:0] sel);
      int w;
      @(negedge clk);
      req_op = op; req_id = id; req_metrics = {m1, m0}; req_mask = mask; metric_sel = sel;
      req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op = OP_ILLEGAL; req_id = ~id; req_metrics = ~req_metrics; req_mask = ~mask;
      lat = 0;
      got_status = 3'b111; got_id = '1; got_val = '0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) begin
            got_status = rsp_status;
            got_id     = rsp_id;
            got_val    = rsp_val;
            break;
         end
      end
      @(negedge clk);
      chk("rsp_pulse_once", 32'(rsp_valid), 32'd0);
   endtask

   task automatic op_chk(input string tag, input logic [2:0] op, input logic [ID_W-1:0] id,
                         input logic [MW-1:0] m0, input logic [MW-1:0] m1, input logic [N-1:0] mask,
                         input logic [SW-1:0] sel, input logic [2:0] exp_st, input int exp_lat);
      do_req(op, id, m0, m1, mask, sel);
      chk({tag, "_status"}, 32'(got_status), 32'(exp_st));
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic read_chk(input string tag, input logic [N-1:0] mask, input logic [SW-1:0] sel,
                           input logic [2:0] exp_st, input int exp_id, input int exp_val);
      op_chk(tag, OP_READ, '0, '0, '0, mask, sel, exp_st, 3);
      chk({tag, "_id"}, 32'(got_id), 32'(exp_id));
      chk({tag, "_val"}, 32'(got_val), 32'(exp_val));
   endtask

   initial begin
      all_ones = '1;
      no_bits  = '0;
      mask_5_9 = '0;
      mask_5_9[5] = 1'b1;
      mask_5_9[9] = 1'b1;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_id = '0; req_metrics = '0;
      req_mask = '0; metric_sel = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_status", 32'(rsp_status), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_val", 32'(rsp_val), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ready", 32'(req_ready), 32'd1);

      // basic inserts and arg-min on both metrics
      op_chk("add5", OP_ADD, 7'd5, 8'd10, 8'd3, no_bits, 1'b0, ST_OK, 3);
      op_chk("add9", OP_ADD, 7'd9, 8'd10, 8'd1, no_bits, 1'b0, ST_OK, 3);
      op_chk("add2", OP_ADD, 7'd2, 8'd4, 8'd7, no_bits, 1'b0, ST_OK, 3);
      read_chk("min_sel0", all_ones, 1'b0, ST_OK, 2, 4);
      read_chk("min_sel1", all_ones, 1'b1, ST_OK, 9, 1);
      chk("count3", 32'(count), 32'd3);

      // equal values keep insertion order
      read_chk("tie_5_first", mask_5_9, 1'b0, ST_OK, 5, 10);
      op_chk("del5", OP_DELETE, 7'd5, 8'd0, 8'd0, no_bits, 1'b0, ST_OK, 3);
      read_chk("tie_after_del", mask_5_9, 1'b0, ST_OK, 9, 10);
      chk("count2", 32'(count), 32'd2);

      // error responses
      op_chk("dup9", OP_ADD, 7'd9, 8'd1, 8'd1, no_bits, 1'b0, ST_DUPLICATE, 3);
      chk("count_after_dup", 32'(count), 32'd2);
      op_chk("del77", OP_DELETE, 7'd77, 8'd0, 8'd0, no_bits, 1'b0, ST_NOT_FOUND, 3);
      op_chk("badop", OP_ILLEGAL, 7'd1, 8'd0, 8'd0, no_bits, 1'b0, ST_BAD_OP, 3);
      read_chk("min_nomask", no_bits, 1'b0, ST_NOT_FOUND, 0, 8'hFF);

      // fill every remaining ID; m0 = 1 + i%100 puts ids 0 and 100 tied at the minimum
      for (int i = 0; i < N; i++) begin
         if (i != 2 && i != 9)
            op_chk("fill_add", OP_ADD, 7'(i), 8'(1 + i % 100), 8'(50 + i % 100), no_bits, 1'b0, ST_OK, 3);
      end
      chk("fill_count", 32'(count), 32'd128);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_empty", 32'(empty), 32'd0);
      read_chk("full_min_sel0", all_ones, 1'b0, ST_OK, 0, 1);
      // every ID is present when the table is full, so duplicate wins over full
      op_chk("full_dup", OP_ADD, 7'd64, 8'd3, 8'd3, no_bits, 1'b0, ST_DUPLICATE, 3);
      op_chk("del0", OP_DELETE, 7'd0, 8'd0, 8'd0, no_bits, 1'b0, ST_OK, 3);
      chk("del0_full", 32'(full), 32'd0);
      chk("del0_count", 32'(count), 32'd127);
      op_chk("readd0", OP_ADD, 7'd0, 8'd1, 8'd50, no_bits, 1'b0, ST_OK, 3);
      chk("readd0_full", 32'(full), 32'd1);
      read_chk("readd0_tie", all_ones, 1'b0, ST_OK, 100, 1);

      // update re-places the entry in both lists
      op_chk("upd9", OP_UPDATE, 7'd9, 8'd0, 8'd200, no_bits, 1'b0, ST_OK, 5);
      chk("upd_count", 32'(count), 32'd128);
      read_chk("upd_sel0", all_ones, 1'b0, ST_OK, 9, 0);
      read_chk("upd_sel1", all_ones, 1'b1, ST_OK, 2, 7);

      // clear, then absent update and empty read
      op_chk("clear", OP_CLEAR, 7'd0, 8'd0, 8'd0, no_bits, 1'b0, ST_OK, 3);
      chk("clear_count", 32'(count), 32'd0);
      chk("clear_empty", 32'(empty), 32'd1);
      chk("clear_full", 32'(full), 32'd0);
      read_chk("clear_read", all_ones, 1'b0, ST_NOT_FOUND, 0, 8'hFF);
      op_chk("upd_absent", OP_UPDATE, 7'd50, 8'd1, 8'd1, no_bits, 1'b0, ST_NOT_FOUND, 3);

      // reset during COMMIT of an ADD discards everything and suppresses the response
      op_chk("add11", OP_ADD, 7'd11, 8'd5, 8'd5, no_bits, 1'b0, ST_OK, 3);
      op_chk("add12", OP_ADD, 7'd12, 8'd6, 8'd6, no_bits, 1'b0, ST_OK, 3);
      @(negedge clk);
      req_op = OP_ADD; req_id = 7'd40; req_metrics = {8'd2, 8'd2}; req_valid = 1'b1;
      chk("abort_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      saw_rsp = 1'b0;
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready_after", 32'(req_ready), 32'd1);
      chk("abort_count", 32'(count), 32'd0);
      chk("abort_empty", 32'(empty), 32'd1);
      for (int c = 0; c < 4; c++) begin
         saw_rsp = saw_rsp | rsp_valid;
         @(negedge clk);
      end
      chk("abort_no_rsp", 32'(saw_rsp), 32'd0);
      read_chk("abort_read", all_ones, 1'b0, ST_NOT_FOUND, 0, 8'hFF);
      op_chk("post_rst_add", OP_ADD, 7'd40, 8'd2, 8'd2, no_bits, 1'b0, ST_OK, 3);
      read_chk("post_rst_read", all_ones, 1'b1, ST_OK, 40, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
